pipe_stage_reg: RTL

- Generic, parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data payload, with a valid/ready handshake, stall back-pressure, synchronous flush and bubble (NOP) insertion.
- An optional second skid entry breaks the combinational ready path between stages.
- Sits between any two pipeline stages of the MIPS32 datapath.

---
 rtl/pipe_stage_pkg.sv | 12 +
 rtl/pipe_stage_slot.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared widths, types and constants for the generic pipeline stage register.
package pipe_stage_pkg;

  localparam int unsigned OCC_W       = 2;
  localparam int unsigned STALL_CNT_W = 32;

  // Replicated to CTRL_W at each use site to form the NOP control bundle.
  localparam logic CTRL_NOP = 1'b0;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry (valid + control + payload) of a pipeline stage register.
// Clearing drops valid and zeroes control but keeps the payload bits.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{CTRL_NOP}};
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{CTRL_NOP}};
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, flush and bubble insertion.
// Optional stall-cycle counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
  logic [DATA_W-1:0] m_data, s_data, m_data_d;
  logic              m_load, m_clear, s_load, s_clear;
  logic              m_valid_d, s_valid_d;
  logic              in_fire, out_fire, m_take;
  occ_t              occ_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign m_take   = ~m_valid | out_fire;

  // M refills from S first, then from the input; S only catches input while M is stalled.
  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_ctrl_d  = in_ctrl;
    m_data_d  = in_data;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (m_take) begin
      if (s_valid) begin
        m_load   = 1'b1;
        m_ctrl_d = s_ctrl;
        m_data_d = s_data;
        s_clear  = 1'b1;
      end else if (in_fire) begin
        m_load = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (in_fire) begin
      s_load = 1'b1;
    end
  end

  assign m_valid_d = ~flush & (m_take ? (s_valid | in_fire) : 1'b1);
  assign s_valid_d = ~flush & ~m_take & (s_valid | in_fire);

  pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
    .clock   (clock),
    .reset   (reset),
    .load    (m_load),
    .clear   (m_clear),
    .ctrl_i  (m_ctrl_d),
    .data_i  (m_data_d),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
      .clock   (clock),
      .reset   (reset),
      .load    (s_load),
      .clear   (s_clear),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .data_o  (s_data)
    );

    // Registered ready: no combinational path from out_ready.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) in_ready_q <= 1'b1;
      else       in_ready_q <= ~s_valid_d;
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign s_valid  = 1'b0;
    assign s_ctrl   = '0;
    assign s_data   = '0;
    assign in_ready = ~m_valid | out_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_t'(m_valid_d) + occ_t'(s_valid_d);
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign occupancy = occ_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Saturating count of cycles where an entry waits on downstream; survives flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  stall_q <= '0;
    else if (m_valid & ~out_ready & ~(&stall_q)) stall_q <= stall_q + STALL_CNT_W'(1);
  end

  assign stall_cycles = stall_q;
`endif

endmodule
